ref_cache_lookup_ctrl: RTL
==========================

Name: ref_cache_lookup_ctrl

Overview:
- Control stage wrapped around the 8-way tag comparator of the reference-pixel cache.
- Owns the per-set valid bits and the tree-PLRU state, and drives valid bits into the comparator.
- Consumes the comparator's hit/way result, selects a victim way on a miss, and sequences the fill request and tag write.
- Returns a hit/way response to the prediction fetch logic.

Parameters:
C_N_WAY, 3, log2 of associativity (8 ways; logic below is written for exactly 8)
SET_WDTH, 5, set index width (32 sets)
TAG_ADDR_WDTH, 12, tag width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  lookup request
req_ready  out  1  request accepted when valid&ready
req_set  in  SET_WDTH  set index
req_tag  in  TAG_ADDR_WDTH  tag
valid_bits_out  out  8  valid bits of latched set, to comparator
cmp_tag_out  out  TAG_ADDR_WDTH  latched tag, to comparator
cmp_hit  in  1  comparator hit
cmp_way  in  C_N_WAY  comparator hit way
fill_req_valid  out  1  miss fill request
fill_req_ready  in  1  fill request accepted
fill_set  out  SET_WDTH  set to fill
fill_way  out  C_N_WAY  victim way
fill_tag  out  TAG_ADDR_WDTH  tag being filled
fill_done  in  1  one-cycle pulse, data written
tag_wr_en  out  1  one-cycle tag memory write
tag_wr_set  out  SET_WDTH  tag memory write set
tag_wr_way  out  C_N_WAY  tag memory write way
tag_wr_tag  out  TAG_ADDR_WDTH  tag memory write data
resp_valid  out  1  response
resp_ready  in  1  response consumed
resp_hit  out  1  1 = hit, 0 = miss that was filled
resp_way  out  C_N_WAY  way holding the data
flush  in  1  invalidate all sets

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All valid bits 0; all PLRU bits 0.
  - All outputs 0, except req_ready=0 during reset and 1 in IDLE.
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
- IDLE:
  - req_ready=1 only when flush=0.
  - flush=1 in IDLE: in one cycle, clear all valid bits and PLRU bits; stay IDLE. flush outranks req_valid in the same cycle.
  - On accept: latch req_set and req_tag; go to LOOKUP. Tag memory read is issued externally the same cycle.
- LOOKUP (one cycle):
  - valid_bits_out and cmp_tag_out are driven from latched values; the comparator result is sampled this cycle.
  - cmp_hit=1: resp_way=cmp_way, resp_hit=1; touch PLRU with cmp_way; go to RESP. Hit latency is 2 cycles from accept to resp_valid.
  - cmp_hit=0: pick the victim; go to MISS_REQ.
- Victim selection:
  - Lowest-index invalid way if any.
  - Otherwise walk the PLRU tree: 7 bits per set, nodes 0..6.
  - At node n, bit 0 goes to child 2n+1 and bit 1 goes to 2n+2.
  - Leaf node n (3..6) selects way 2(n-3) + bit.
- PLRU touch of way w:
  - node0 = ~w[2]
  - node(1+w[2]) = ~w[1]
  - node(3+w[2:1]) = ~w[0]
  - Other bits are unchanged.
- MISS_REQ:
  - fill_req_valid=1 with fill_set, fill_way and fill_tag stable until fill_req_ready.
  - The victim's valid bit is cleared on entry.
  - On handshake, go to MISS_WAIT.
- MISS_WAIT:
  - On fill_done:
    - tag_wr_en=1 for that cycle with the latched set, victim way and tag.
    - Set the valid bit and touch PLRU with the victim.
    - resp_hit=0, resp_way=victim; go to RESP.
  - fill_done in any other state is ignored.
- RESP:
  - resp_valid=1, holding resp_hit and resp_way until resp_ready.
  - Then go to IDLE; the next request can be accepted the following cycle.
- flush outside IDLE: ignored until the block returns to IDLE. flush is level-sampled, so the caller holds it.
- Reset mid-miss: fill_req_valid drops immediately (async) and all state is lost. The external fill path must be reset together with this block.
- Only one request is in flight; req_ready=0 in every state other than IDLE.

Optional Feature:
REF_CACHE_STATS_EN:
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - Incremented in LOOKUP on hit or miss respectively.
  - Saturate at 32'hFFFFFFFF; cleared by reset and by an accepted flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Post-reset request set=3, tag=0x0A5, cmp_hit=0:
  - Victim way 0; fill_req set=3, way=0, tag=0x0A5.
  - After fill_done: tag_wr_en pulse; resp_hit=0, resp_way=0; valid_bits for set 3 = 8'h01.
- Fill all 8 ways of set 3 (ways 0..7 in order), then miss:
  - Victim is way 0. PLRU after touching 0..7 in order points to 0.
  - Touching way 0 via a hit, then another miss, gives victim way 4.
- Request set=3, cmp_hit=1, cmp_way=5:
  - resp_valid 2 cycles after accept with resp_hit=1, resp_way=5.
  - PLRU node0=0, node2=1, node5=0.
- fill_req_ready held low 10 cycles: fill_req outputs stay stable; fill_done pulsed during MISS_REQ is ignored; resp_valid does not assert.
- flush and req_valid asserted together in IDLE:
  - Flush wins and req_ready=0; all valid bits become 0.
  - The next request to set 3 misses with victim way 0.
- reset_n low during MISS_WAIT:
  - fill_req_valid and resp_valid drop to 0 immediately.
  - After release, the block is in IDLE with req_ready=1 and valid_bits_out=0.

Source files
------------

// File: rtl/ref_cache_lookup_ctrl_if.sv
// Handshake bundle between the lookup controller and its requester, comparator,
// fill path and tag memory. The controller uses the slave modport.
interface ref_cache_lookup_ctrl_if #(
  parameter int unsigned C_N_WAY       = 3,
  parameter int unsigned SET_WDTH      = 5,
  parameter int unsigned TAG_ADDR_WDTH = 12
);
  logic                     req_valid;
  logic                     req_ready;
  logic [SET_WDTH-1:0]      req_set;
  logic [TAG_ADDR_WDTH-1:0] req_tag;
  logic [7:0]               valid_bits_out;
  logic [TAG_ADDR_WDTH-1:0] cmp_tag_out;
  logic                     cmp_hit;
  logic [C_N_WAY-1:0]       cmp_way;
  logic                     fill_req_valid;
  logic                     fill_req_ready;
  logic [SET_WDTH-1:0]      fill_set;
  logic [C_N_WAY-1:0]       fill_way;
  logic [TAG_ADDR_WDTH-1:0] fill_tag;
  logic                     fill_done;
  logic                     tag_wr_en;
  logic [SET_WDTH-1:0]      tag_wr_set;
  logic [C_N_WAY-1:0]       tag_wr_way;
  logic [TAG_ADDR_WDTH-1:0] tag_wr_tag;
  logic                     resp_valid;
  logic                     resp_ready;
  logic                     resp_hit;
  logic [C_N_WAY-1:0]       resp_way;
  logic                     flush;

  modport master (
    output req_valid, req_set, req_tag, cmp_hit, cmp_way, fill_req_ready, fill_done,
           resp_ready, flush,
    input  req_ready, valid_bits_out, cmp_tag_out, fill_req_valid, fill_set, fill_way,
           fill_tag, tag_wr_en, tag_wr_set, tag_wr_way, tag_wr_tag, resp_valid, resp_hit,
           resp_way
  );

  modport slave (
    input  req_valid, req_set, req_tag, cmp_hit, cmp_way, fill_req_ready, fill_done,
           resp_ready, flush,
    output req_ready, valid_bits_out, cmp_tag_out, fill_req_valid, fill_set, fill_way,
           fill_tag, tag_wr_en, tag_wr_set, tag_wr_way, tag_wr_tag, resp_valid, resp_hit,
           resp_way
  );
endinterface

// File: rtl/ref_cache_lookup_ctrl.sv
// Lookup control for the 8-way reference-pixel cache: valid bits, tree-PLRU, miss fill.
// Define REF_CACHE_STATS_EN to add saturating hit/miss counters.
module ref_cache_lookup_ctrl #(
  parameter int unsigned C_N_WAY       = 3,
  parameter int unsigned SET_WDTH      = 5,
  parameter int unsigned TAG_ADDR_WDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  ref_cache_lookup_ctrl_if.slave  bus
`ifdef REF_CACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);

  localparam int unsigned NumSets = 1 << SET_WDTH;

  typedef enum logic [2:0] {StIdle, StLookup, StMissReq, StMissWait, StResp} state_e;

  state_e                            state_q, state_d;
  logic [SET_WDTH-1:0]               set_q, set_d;
  logic [TAG_ADDR_WDTH-1:0]          tag_q, tag_d;
  logic [C_N_WAY-1:0]                way_q, way_d;
  logic                              hit_q, hit_d;
  logic [NumSets-1:0][7:0]           valid_q, valid_d;
  logic [NumSets-1:0][6:0]           plru_q, plru_d;
  logic [C_N_WAY-1:0]                victim;

  function automatic logic [2:0] pick_victim(input logic [7:0] v, input logic [6:0] p);
    logic [2:0] w;
    logic       found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && !v[i]) begin
        w     = 3'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      w[2] = p[0];
      w[1] = w[2] ? p[2] : p[1];
      case (w[2:1])
        2'd0:    w[0] = p[3];
        2'd1:    w[0] = p[4];
        2'd2:    w[0] = p[5];
        default: w[0] = p[6];
      endcase
    end
    return w;
  endfunction

  // Point every node on the path to w away from w.
  function automatic logic [6:0] touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] r;
    r    = p;
    r[0] = ~w[2];
    if (w[2]) r[2] = ~w[1];
    else      r[1] = ~w[1];
    case (w[2:1])
      2'd0:    r[3] = ~w[0];
      2'd1:    r[4] = ~w[0];
      2'd2:    r[5] = ~w[0];
      default: r[6] = ~w[0];
    endcase
    return r;
  endfunction

  assign victim = pick_victim(valid_q[set_q], plru_q[set_q]);

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    tag_d   = tag_q;
    way_d   = way_q;
    hit_d   = hit_q;
    valid_d = valid_q;
    plru_d  = plru_q;
    case (state_q)
      StIdle: begin
        if (bus.flush) begin
          valid_d = '0;
          plru_d  = '0;
        end else if (bus.req_valid) begin
          set_d   = bus.req_set;
          tag_d   = bus.req_tag;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (bus.cmp_hit) begin
          way_d          = bus.cmp_way;
          hit_d          = 1'b1;
          plru_d[set_q]  = touch(plru_q[set_q], bus.cmp_way);
          state_d        = StResp;
        end else begin
          way_d                 = victim;
          hit_d                 = 1'b0;
          valid_d[set_q][victim] = 1'b0;
          state_d               = StMissReq;
        end
      end
      StMissReq: begin
        if (bus.fill_req_ready) state_d = StMissWait;
      end
      StMissWait: begin
        if (bus.fill_done) begin
          valid_d[set_q][way_q] = 1'b1;
          plru_d[set_q]         = touch(plru_q[set_q], way_q);
          state_d               = StResp;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      set_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  // reset_n gating keeps req_ready low while reset is asserted.
  assign bus.req_ready      = reset_n && (state_q == StIdle) && !bus.flush;
  assign bus.valid_bits_out = valid_q[set_q];
  assign bus.cmp_tag_out    = tag_q;
  assign bus.fill_req_valid = (state_q == StMissReq);
  assign bus.fill_set       = set_q;
  assign bus.fill_way       = way_q;
  assign bus.fill_tag       = tag_q;
  assign bus.tag_wr_en      = (state_q == StMissWait) && bus.fill_done;
  assign bus.tag_wr_set     = set_q;
  assign bus.tag_wr_way     = way_q;
  assign bus.tag_wr_tag     = tag_q;
  assign bus.resp_valid     = (state_q == StResp);
  assign bus.resp_hit       = hit_q;
  assign bus.resp_way       = way_q;

`ifdef REF_CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == StIdle && bus.flush) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == StLookup) begin
      if (bus.cmp_hit) begin
        if (hits_q != '1) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule
